stream_mux_arb: RTL

//  Parametrised N-channel, W-bit registered stream multiplexer; successor to the fixed 2:1/4:1 muxes.

---
 rtl/stream_mux_pkg.sv | 13 +
 rtl/stream_mux_arb_rr_arbiter.sv | 52 +++++
 rtl/stream_mux_arb.sv | 102 ++++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the N-channel registered stream multiplexer.
// Mode encodings and the select-width helper used by the top and arbiter.
package stream_mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Channel-id width; a 1- or 2-channel mux still needs a 1-bit id.
  function automatic int unsigned clog2_safe(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : stream_mux_pkg

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests to start after ptr,
// priority-encode the lowest set bit, then rotate the offset back.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int unsigned N_CH  = 4,
  localparam int unsigned SEL_W = clog2_safe(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_vld,
  output logic [SEL_W-1:0] gnt_id
);

  logic [SEL_W-1:0] w_start;
  logic [N_CH-1:0]  w_rot;
  logic [SEL_W-1:0] w_off;
  logic [SEL_W:0]   w_sum;
  int               w_idx;

  // Search starts one past the last winner; pointer at the top wraps to ch0.
  always_comb begin
    w_start = (32'(ptr) >= N_CH - 1) ? '0 : ptr + SEL_W'(1);
  end

  always_comb begin
    w_rot = '0;
    w_idx = 0;
    for (int k = 0; k < int'(N_CH); k++) begin
      w_idx = int'(w_start) + k;
      if (w_idx >= int'(N_CH)) w_idx = w_idx - int'(N_CH);
      w_rot[k] = req[w_idx];
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    w_off   = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        gnt_vld = 1'b1;
        w_off   = SEL_W'(i);
      end
    end
  end

  always_comb begin
    w_sum  = (SEL_W+1)'(w_start) + (SEL_W+1)'(w_off);
    gnt_id = (32'(w_sum) >= N_CH) ? SEL_W'(w_sum - (SEL_W+1)'(N_CH)) : SEL_W'(w_sum);
  end

endmodule : rr_arbiter

// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream mux with external-select or round-robin choice
// feeding a single registered output stage.
module stream_mux_arb
  import stream_mux_pkg::*;
#(
  parameter  int unsigned N_CH   = 4,
  parameter  int unsigned DATA_W = 8,
  localparam int unsigned SEL_W  = clog2_safe(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SEL_W-1:0]       out_ch
);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [SEL_W-1:0]  r_out_ch;
  logic [SEL_W-1:0]  r_rr_ptr;

  logic              w_load_en;
  logic              w_sel_vld;
  logic              w_rr_vld;
  logic [SEL_W-1:0]  w_rr_id;
  logic              w_gnt_vld;
  logic [SEL_W-1:0]  w_gnt_id;
  logic              w_xfer;
  logic [DATA_W-1:0] w_data;

  rr_arbiter #(.N_CH(N_CH)) u_rr_arbiter (
    .req     (in_valid),
    .ptr     (r_rr_ptr),
    .gnt_vld (w_rr_vld),
    .gnt_id  (w_rr_id)
  );

  assign w_load_en = !r_out_valid || out_ready;

  // Explicit compare loop keeps out-of-range sel idle and X-free.
  always_comb begin
    w_sel_vld = 1'b0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if ((sel == SEL_W'(i)) && in_valid[i]) w_sel_vld = 1'b1;
    end
  end

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    if (mode == MODE_RR) begin
      w_gnt_vld = w_rr_vld;
      w_gnt_id  = w_rr_id;
    end else begin
      w_gnt_vld = w_sel_vld;
      w_gnt_id  = sel;
    end
  end

  assign w_xfer = w_gnt_vld && w_load_en;

  always_comb begin
    in_ready = '0;
    w_data   = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (w_gnt_id == SEL_W'(i)) begin
        in_ready[i] = w_xfer;
        w_data      = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output stage and round-robin pointer; pointer moves only on RR transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_rr_ptr    <= SEL_W'(N_CH - 1);
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_data;
        r_out_ch    <= w_gnt_id;
        if (mode == MODE_RR) r_rr_ptr <= w_gnt_id;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule : stream_mux_arb
